// File: rtl/id_stage_pipe_if.sv
// =============================================================================
// id_stage_pipe_if : IF/ID input handshake and registered ID/EX bundle. Rev 1.0
// =============================================================================
`default_nettype none

interface id_stage_pipe_if #(
  parameter int XLEN     = 32,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
);
  logic                in_valid;
  logic                in_ready;
  logic [XLEN-1:0]     pc_i;
  logic [31:0]         inst_i;
  logic                flush_i;
  logic                out_valid;
  logic                out_ready;
  logic [ALUOP_W-1:0]  aluop_o;
  logic [ALUSEL_W-1:0] alusel_o;
  logic [XLEN-1:0]     op1_o;
  logic [XLEN-1:0]     op2_o;
  logic [XLEN-1:0]     pc_o;
  logic                w_enable_o;
  logic [4:0]          w_addr_o;
  logic                illegal_o;

  modport master (
    output in_valid, pc_i, inst_i, flush_i, out_ready,
    input  in_ready, out_valid, aluop_o, alusel_o, op1_o, op2_o, pc_o,
           w_enable_o, w_addr_o, illegal_o
  );

  modport slave (
    input  in_valid, pc_i, inst_i, flush_i, out_ready,
    output in_ready, out_valid, aluop_o, alusel_o, op1_o, op2_o, pc_o,
           w_enable_o, w_addr_o, illegal_o
  );
endinterface

`default_nettype wire

// File: rtl/id_stage_pipe.sv
// =============================================================================
// id_stage_pipe : RV32 decode with priority forwarding and load-use stall. Rev 1.0
// =============================================================================
`default_nettype none

module id_stage_pipe #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  id_stage_pipe_if.slave               bus,
  output logic                         r1_enable_o,
  output logic                         r2_enable_o,
  output logic [4:0]                   r1_addr_o,
  output logic [4:0]                   r2_addr_o,
  input  wire logic [XLEN-1:0]         r1_data_i,
  input  wire logic [XLEN-1:0]         r2_data_i,
  input  wire logic [NUM_FWD-1:0]      fwd_enable_i,
  input  wire logic [5*NUM_FWD-1:0]    fwd_addr_i,
  input  wire logic [XLEN*NUM_FWD-1:0] fwd_data_i,
  input  wire logic                    ex_load_i
);
  localparam logic [7:0] EX_NOP_OP  = 8'h00;
  localparam logic [7:0] EX_ADD_OP  = 8'h01;
  localparam logic [7:0] EX_SUB_OP  = 8'h02;
  localparam logic [7:0] EX_SLT_OP  = 8'h03;
  localparam logic [7:0] EX_SLTU_OP = 8'h04;
  localparam logic [7:0] EX_XOR_OP  = 8'h05;
  localparam logic [7:0] EX_OR_OP   = 8'h06;
  localparam logic [7:0] EX_AND_OP  = 8'h07;
  localparam logic [7:0] EX_SLL_OP  = 8'h08;
  localparam logic [7:0] EX_SRL_OP  = 8'h09;
  localparam logic [7:0] EX_SRA_OP  = 8'h0A;

  localparam logic [2:0] EX_RES_NOP   = 3'd0;
  localparam logic [2:0] EX_RES_LOGIC = 3'd1;
  localparam logic [2:0] EX_RES_SHIFT = 3'd2;
  localparam logic [2:0] EX_RES_ARITH = 3'd3;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;

  logic [6:0]      w_opcode, w_funct7;
  logic [2:0]      w_funct3;
  logic [4:0]      w_rd, w_rs1, w_rs2, w_fwd0_addr;
  logic [XLEN-1:0] w_imm_i, w_imm_sh, w_imm_u, w_imm, w_op1, w_op2;
  logic            w_r1_en, w_r2_en, w_we, w_illegal, w_use_pc;
  logic [7:0]      w_aluop;
  logic [2:0]      w_alusel;
  logic            w_stall, w_load, w_take;

  logic            r_out_valid, r_we, r_illegal;
  logic [7:0]      r_aluop;
  logic [2:0]      r_alusel;
  logic [XLEN-1:0] r_op1, r_op2, r_pc;
  logic [4:0]      r_waddr;

  assign w_opcode = bus.inst_i[6:0];
  assign w_rd     = bus.inst_i[11:7];
  assign w_funct3 = bus.inst_i[14:12];
  assign w_rs1    = bus.inst_i[19:15];
  assign w_rs2    = bus.inst_i[24:20];
  assign w_funct7 = bus.inst_i[31:25];
  assign w_imm_i  = XLEN'(signed'(bus.inst_i[31:20]));
  assign w_imm_sh = XLEN'(bus.inst_i[24:20]);
  assign w_imm_u  = XLEN'(signed'({bus.inst_i[31:12], 12'b0}));

  always_comb begin
    w_r1_en   = 1'b0;
    w_r2_en   = 1'b0;
    w_we      = 1'b0;
    w_illegal = 1'b0;
    w_use_pc  = 1'b0;
    w_imm     = '0;
    w_aluop   = EX_NOP_OP;
    w_alusel  = EX_RES_NOP;
    case (w_opcode)
      OPC_LUI, OPC_AUIPC: begin
        w_we     = 1'b1;
        w_use_pc = (w_opcode == OPC_AUIPC);
        w_imm    = w_imm_u;
        w_aluop  = EX_ADD_OP;
        w_alusel = EX_RES_ARITH;
      end
      OPC_LOAD: w_we = 1'b1;
      OPC_OPIMM: begin
        w_r1_en = 1'b1;
        w_we    = 1'b1;
        w_imm   = w_imm_i;
        case (w_funct3)
          3'b000: begin w_aluop = EX_ADD_OP;  w_alusel = EX_RES_ARITH; end
          3'b010: begin w_aluop = EX_SLT_OP;  w_alusel = EX_RES_ARITH; end
          3'b011: begin w_aluop = EX_SLTU_OP; w_alusel = EX_RES_ARITH; end
          3'b100: begin w_aluop = EX_XOR_OP;  w_alusel = EX_RES_LOGIC; end
          3'b110: begin w_aluop = EX_OR_OP;   w_alusel = EX_RES_LOGIC; end
          3'b111: begin w_aluop = EX_AND_OP;  w_alusel = EX_RES_LOGIC; end
          3'b001: begin
            w_imm = w_imm_sh;
            if (w_funct7 == 7'h00) begin w_aluop = EX_SLL_OP; w_alusel = EX_RES_SHIFT; end
            else w_illegal = 1'b1;
          end
          default: begin
            w_imm = w_imm_sh;
            if (w_funct7 == 7'h00)      begin w_aluop = EX_SRL_OP; w_alusel = EX_RES_SHIFT; end
            else if (w_funct7 == 7'h20) begin w_aluop = EX_SRA_OP; w_alusel = EX_RES_SHIFT; end
            else w_illegal = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        w_r1_en = 1'b1;
        w_r2_en = 1'b1;
        w_we    = 1'b1;
        case ({w_funct7, w_funct3})
          {7'h00, 3'b000}: begin w_aluop = EX_ADD_OP;  w_alusel = EX_RES_ARITH; end
          {7'h20, 3'b000}: begin w_aluop = EX_SUB_OP;  w_alusel = EX_RES_ARITH; end
          {7'h00, 3'b010}: begin w_aluop = EX_SLT_OP;  w_alusel = EX_RES_ARITH; end
          {7'h00, 3'b011}: begin w_aluop = EX_SLTU_OP; w_alusel = EX_RES_ARITH; end
          {7'h00, 3'b100}: begin w_aluop = EX_XOR_OP;  w_alusel = EX_RES_LOGIC; end
          {7'h00, 3'b110}: begin w_aluop = EX_OR_OP;   w_alusel = EX_RES_LOGIC; end
          {7'h00, 3'b111}: begin w_aluop = EX_AND_OP;  w_alusel = EX_RES_LOGIC; end
          {7'h00, 3'b001}: begin w_aluop = EX_SLL_OP;  w_alusel = EX_RES_SHIFT; end
          {7'h00, 3'b101}: begin w_aluop = EX_SRL_OP;  w_alusel = EX_RES_SHIFT; end
          {7'h20, 3'b101}: begin w_aluop = EX_SRA_OP;  w_alusel = EX_RES_SHIFT; end
          default:         w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
    // An undecodable word must not read, write, or carry a stray immediate.
    if (w_illegal) begin
      w_r1_en  = 1'b0;
      w_r2_en  = 1'b0;
      w_we     = 1'b0;
      w_imm    = '0;
      w_aluop  = EX_NOP_OP;
      w_alusel = EX_RES_NOP;
    end
  end

  // Descending scan so the youngest matching source (lowest index) wins.
  always_comb begin
    w_op1 = '0;
    w_op2 = w_imm;
    if (w_use_pc) begin
      w_op1 = bus.pc_i;
    end else if (w_r1_en && w_rs1 != 5'd0) begin
      w_op1 = r1_data_i;
      for (int k = NUM_FWD - 1; k >= 0; k--)
        if (fwd_enable_i[k] && fwd_addr_i[5*k +: 5] == w_rs1)
          w_op1 = fwd_data_i[XLEN*k +: XLEN];
    end
    if (w_r2_en) begin
      w_op2 = '0;
      if (w_rs2 != 5'd0) begin
        w_op2 = r2_data_i;
        for (int k = NUM_FWD - 1; k >= 0; k--)
          if (fwd_enable_i[k] && fwd_addr_i[5*k +: 5] == w_rs2)
            w_op2 = fwd_data_i[XLEN*k +: XLEN];
      end
    end
  end

  assign w_fwd0_addr = fwd_addr_i[4:0];
  assign w_stall     = ex_load_i && fwd_enable_i[0] && (w_fwd0_addr != 5'd0) &&
                       ((w_r1_en && w_fwd0_addr == w_rs1) || (w_r2_en && w_fwd0_addr == w_rs2));
  assign w_load      = bus.out_ready || !r_out_valid;
  assign w_take      = bus.in_valid && !w_stall && !bus.flush_i;

  assign bus.in_ready = rst && ((!w_stall && w_load) || bus.flush_i);
  assign r1_enable_o  = rst && w_r1_en;
  assign r2_enable_o  = rst && w_r2_en;
  assign r1_addr_o    = rst ? w_rs1 : 5'd0;
  assign r2_addr_o    = rst ? w_rs2 : 5'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_aluop     <= EX_NOP_OP;
      r_alusel    <= EX_RES_NOP;
      r_op1       <= '0;
      r_op2       <= '0;
      r_pc        <= '0;
      r_we        <= 1'b0;
      r_waddr     <= 5'd0;
      r_illegal   <= 1'b0;
    end else if (bus.flush_i || w_load) begin
      r_out_valid <= w_take;
      if (w_take) begin
        r_aluop   <= w_aluop;
        r_alusel  <= w_alusel;
        r_op1     <= w_op1;
        r_op2     <= w_op2;
        r_pc      <= bus.pc_i;
        r_we      <= w_we;
        r_waddr   <= w_rd;
        r_illegal <= w_illegal;
      end else begin
        r_aluop   <= EX_NOP_OP;
        r_alusel  <= EX_RES_NOP;
        r_op1     <= '0;
        r_op2     <= '0;
        r_pc      <= '0;
        r_we      <= 1'b0;
        r_waddr   <= 5'd0;
        r_illegal <= 1'b0;
      end
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.aluop_o    = r_aluop;
  assign bus.alusel_o   = r_alusel;
  assign bus.op1_o      = r_op1;
  assign bus.op2_o      = r_op2;
  assign bus.pc_o       = r_pc;
  assign bus.w_enable_o = r_we;
  assign bus.w_addr_o   = r_waddr;
  assign bus.illegal_o  = r_illegal;
endmodule

`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
// =============================================================================
// tb_id_stage_pipe : directed self-checking bench for id_stage_pipe. Rev 1.0
// =============================================================================
`default_nettype none

module tb_id_stage_pipe;
  localparam logic [7:0] EX_NOP_OP    = 8'h00;
  localparam logic [7:0] EX_ADD_OP    = 8'h01;
  localparam logic [7:0] EX_SRA_OP    = 8'h0A;
  localparam logic [2:0] EX_RES_NOP   = 3'd0;
  localparam logic [2:0] EX_RES_SHIFT = 3'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        r1_enable, r2_enable;
  logic [4:0]  r1_addr, r2_addr;
  logic [31:0] r1_data = '0, r2_data = '0;
  logic [1:0]  fwd_enable = '0;
  logic [9:0]  fwd_addr = '0;
  logic [63:0] fwd_data = '0;
  logic        ex_load = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  id_stage_pipe_if #(.XLEN(32)) bus ();

  id_stage_pipe #(.XLEN(32), .NUM_FWD(2)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .r1_enable_o(r1_enable), .r2_enable_o(r2_enable),
    .r1_addr_o(r1_addr), .r2_addr_o(r2_addr),
    .r1_data_i(r1_data), .r2_data_i(r2_data),
    .fwd_enable_i(fwd_enable), .fwd_addr_i(fwd_addr), .fwd_data_i(fwd_data),
    .ex_load_i(ex_load)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] inst, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.inst_i   = inst;
    bus.pc_i     = pc;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.inst_i = $urandom; bus.pc_i = $urandom;
      bus.out_ready = 1'($urandom); bus.flush_i = 1'b0;
      r1_data = $urandom; r2_data = $urandom; fwd_enable = 2'($urandom);
      fwd_addr = 10'($urandom); fwd_data = {$urandom, $urandom}; ex_load = 1'($urandom);
      step();
    end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0h want 0", bus.out_valid); end
    n_cmp++; if (bus.op1_o !== 32'h0 || bus.op2_o !== 32'h0) begin n_bad++; $display("FAIL reset_ops: got %h/%h want 0/0", bus.op1_o, bus.op2_o); end
    n_cmp++; if (bus.w_enable_o !== 1'b0) begin n_bad++; $display("FAIL reset_w_enable: got %0h want 0", bus.w_enable_o); end
    n_cmp++; if (r1_enable !== 1'b0 || r1_addr !== 5'd0) begin n_bad++; $display("FAIL reset_read_port: got en=%0h addr=%0d want 0/0", r1_enable, r1_addr); end
    rst = 1'b1;
    bus.out_ready = 1'b1; fwd_enable = '0; fwd_addr = '0; fwd_data = '0; ex_load = 1'b0;
    present(32'hFFF00093, 32'h0000_0040);
    step();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL addi_out_valid: got %0h want 1", bus.out_valid); end
    n_cmp++; if (bus.op2_o !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL addi_op2: got %h want ffffffff", bus.op2_o); end
    n_cmp++; if (bus.w_addr_o !== 5'd1 || bus.w_enable_o !== 1'b1) begin n_bad++; $display("FAIL addi_wb: got addr=%0d we=%0h want 1/1", bus.w_addr_o, bus.w_enable_o); end
    n_cmp++; if (bus.op1_o !== 32'h0 || bus.aluop_o !== EX_ADD_OP || bus.pc_o !== 32'h40) begin n_bad++; $display("FAIL addi_fields: got op1=%h aluop=%h pc=%h want 0/01/40", bus.op1_o, bus.aluop_o, bus.pc_o); end
  endtask

  task automatic test_forward();
    r1_data = 32'h33; r2_data = 32'h44;
    fwd_addr = {5'd1, 5'd1}; fwd_data = {32'h22, 32'h11}; fwd_enable = 2'b11;
    present(32'h002081B3, 32'h100);
    #1;
    n_cmp++; if (r1_addr !== 5'd1 || r2_addr !== 5'd2 || r1_enable !== 1'b1 || r2_enable !== 1'b1) begin n_bad++; $display("FAIL read_addr: got %0d/%0d en=%0h%0h want 1/2 en=11", r1_addr, r2_addr, r1_enable, r2_enable); end
    step();
    n_cmp++; if (bus.op1_o !== 32'h11 || bus.op2_o !== 32'h44) begin n_bad++; $display("FAIL fwd_youngest: got %h/%h want 11/44", bus.op1_o, bus.op2_o); end
    fwd_enable = 2'b10;
    step();
    n_cmp++; if (bus.op1_o !== 32'h22) begin n_bad++; $display("FAIL fwd_older: got %h want 22", bus.op1_o); end
    fwd_enable = 2'b00;
    step();
    n_cmp++; if (bus.op1_o !== 32'h33) begin n_bad++; $display("FAIL fwd_regfile: got %h want 33", bus.op1_o); end
    fwd_addr = {5'd0, 5'd0}; fwd_enable = 2'b11; r1_data = 32'h99;
    present(32'h002001B3, 32'h104);
    step();
    n_cmp++; if (bus.op1_o !== 32'h0 || bus.op2_o !== 32'h44) begin n_bad++; $display("FAIL fwd_x0: got %h/%h want 0/44", bus.op1_o, bus.op2_o); end
    fwd_enable = 2'b00;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_load_use();
    r2_data = 32'h66;
    fwd_addr = {5'd0, 5'd1}; fwd_data = {32'h0, 32'h55}; fwd_enable = 2'b01; ex_load = 1'b1;
    present(32'h002081B3, 32'h200);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL loaduse_in_ready: got %0h want 0", bus.in_ready); end
    step();
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.aluop_o !== EX_NOP_OP || bus.w_enable_o !== 1'b0) begin n_bad++; $display("FAIL loaduse_bubble: got v=%0h aluop=%h we=%0h want 0/00/0", bus.out_valid, bus.aluop_o, bus.w_enable_o); end
    ex_load = 1'b0;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL loaduse_release: got %0h want 1", bus.in_ready); end
    step();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.op1_o !== 32'h55 || bus.op2_o !== 32'h66 || bus.w_addr_o !== 5'd3) begin n_bad++; $display("FAIL loaduse_accept: got v=%0h op1=%h op2=%h rd=%0d want 1/55/66/3", bus.out_valid, bus.op1_o, bus.op2_o, bus.w_addr_o); end
    fwd_enable = 2'b00;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    present(32'h00700293, 32'h300);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d]: got %0h want 0", i, bus.in_ready); end
      step();
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.op1_o !== 32'h55 || bus.w_addr_o !== 5'd3 || bus.pc_o !== 32'h200) begin n_bad++; $display("FAIL bp_hold[%0d]: got v=%0h op1=%h rd=%0d pc=%h want 1/55/3/200", i, bus.out_valid, bus.op1_o, bus.w_addr_o, bus.pc_o); end
    end
    bus.out_ready = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_resume_ready: got %0h want 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.w_addr_o !== 5'd5 || bus.op2_o !== 32'h7 || bus.op1_o !== 32'h0) begin n_bad++; $display("FAIL bp_next: got v=%0h rd=%0d op2=%h op1=%h want 1/5/7/0", bus.out_valid, bus.w_addr_o, bus.op2_o, bus.op1_o); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0; bus.flush_i = 1'b1;
    fwd_addr = {5'd0, 5'd1}; fwd_enable = 2'b01; ex_load = 1'b1;
    present(32'h002081B3, 32'h400);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready: got %0h want 1", bus.in_ready); end
    step();
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.aluop_o !== EX_NOP_OP || bus.w_enable_o !== 1'b0 || bus.op2_o !== 32'h0) begin n_bad++; $display("FAIL flush_kill: got v=%0h aluop=%h we=%0h op2=%h want 0/00/0/0", bus.out_valid, bus.aluop_o, bus.w_enable_o, bus.op2_o); end
    bus.flush_i = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    fwd_enable = 2'b00; ex_load = 1'b0;
    step();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_dropped: got %0h want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1; r1_data = 32'h8000_0000;
    present(32'hFFFFFFFF, 32'h500);
    step();
    n_cmp++; if (bus.illegal_o !== 1'b1 || bus.w_enable_o !== 1'b0 || bus.aluop_o !== EX_NOP_OP || bus.alusel_o !== EX_RES_NOP || bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL illegal_ones: got ill=%0h we=%0h aluop=%h sel=%0h v=%0h want 1/0/00/0/1", bus.illegal_o, bus.w_enable_o, bus.aluop_o, bus.alusel_o, bus.out_valid); end
    present(32'h40335293, 32'h504);
    step();
    n_cmp++; if (bus.aluop_o !== EX_SRA_OP || bus.alusel_o !== EX_RES_SHIFT || bus.op2_o !== 32'h3 || bus.op1_o !== 32'h8000_0000 || bus.illegal_o !== 1'b0) begin n_bad++; $display("FAIL srai: got aluop=%h sel=%0h op2=%h op1=%h ill=%0h want 0a/2/3/80000000/0", bus.aluop_o, bus.alusel_o, bus.op2_o, bus.op1_o, bus.illegal_o); end
    present(32'h02335293, 32'h508);
    step();
    n_cmp++; if (bus.illegal_o !== 1'b1 || bus.w_enable_o !== 1'b0) begin n_bad++; $display("FAIL srli_bad_f7: got ill=%0h we=%0h want 1/0", bus.illegal_o, bus.w_enable_o); end
    present(32'h123453B7, 32'h50C);
    step();
    n_cmp++; if (bus.op1_o !== 32'h0 || bus.op2_o !== 32'h1234_5000 || bus.w_addr_o !== 5'd7) begin n_bad++; $display("FAIL lui: got op1=%h op2=%h rd=%0d want 0/12345000/7", bus.op1_o, bus.op2_o, bus.w_addr_o); end
    present(32'h00001417, 32'h100);
    step();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.op1_o !== 32'h100 || bus.op2_o !== 32'h1000 || bus.w_addr_o !== 5'd8 || bus.aluop_o !== EX_ADD_OP) begin n_bad++; $display("FAIL auipc: got op1=%h op2=%h rd=%0d aluop=%h want 100/1000/8/01", bus.op1_o, bus.op2_o, bus.w_addr_o, bus.aluop_o); end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.inst_i = '0; bus.pc_i = '0;
    bus.flush_i = 1'b0; bus.out_ready = 1'b1;
    test_reset();
    test_forward();
    test_load_use();
    test_backpressure();
    test_flush();
    test_back_to_back();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
